// File: rtl/key_scan_debounce.sv
// key_scan_debounce: eight push-button debouncers sharing one sample-tick
// prescaler, with press / long-press pulses and a press-event queue that is
// presented one key index at a time.
//
// Event handshake (code_valid / code_ack):
//   code_valid=1 means key_code holds an event that has not been consumed.
//   The event is consumed on any mclk edge where code_valid=1 and code_ack=1.
//   While code_valid=1 and code_ack=0, key_code and code_valid hold steady.
//   code_ack while code_valid=0 has no effect.
module key_scan_debounce #(
  parameter int TICK_DIV = 50000,
  parameter int DEB_N    = 4,
  parameter int LONG_N   = 64
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [7:0] key,
  output logic [7:0] key_lvl,
  output logic [7:0] key_press,
  output logic [7:0] key_long,
  output logic       code_valid,
  output logic [2:0] key_code,
  input  logic       code_ack,
  output logic       ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PCHK = 2'd1,
    S_DOWN = 2'd2,
    S_RCHK = 2'd3
  } state_t;

  // Per-key FSM state grouped so it can be probed as gen_key[i].fsm.
  typedef struct packed {
    state_t     st;
    logic [3:0] cnt;
    logic [7:0] hold;
  } key_fsm_t;

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [PW-1:0] pcnt;
  logic          tick;

  // Two-flop synchronizer on the raw key levels.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Sample-tick prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < 8; g++) begin : gen_key
    key_fsm_t fsm;
    logic     lvl_r;
    logic     press_r;
    logic     long_r;
    logic     smp;

    assign smp = sync2[g];

    // Debounce FSM: advances only on tick cycles; pulse outputs default low.
    always_ff @(posedge mclk or posedge rst) begin
      if (rst) begin
        fsm.st   <= S_IDLE;
        fsm.cnt  <= '0;
        fsm.hold <= '0;
        lvl_r    <= 1'b0;
        press_r  <= 1'b0;
        long_r   <= 1'b0;
      end else begin
        press_r <= 1'b0;
        long_r  <= 1'b0;
        if (tick) begin
          case (fsm.st)
            S_IDLE: begin
              if (smp) begin
                fsm.st  <= S_PCHK;
                fsm.cnt <= 4'd1;
              end
            end
            S_PCHK: begin
              if (smp) begin
                if (fsm.cnt == 4'(DEB_N - 1)) begin
                  fsm.st   <= S_DOWN;
                  fsm.cnt  <= '0;
                  fsm.hold <= '0;
                  lvl_r    <= 1'b1;
                  press_r  <= 1'b1;
                end else begin
                  fsm.cnt <= fsm.cnt + 4'd1;
                end
              end else begin
                fsm.st  <= S_IDLE;
                fsm.cnt <= '0;
              end
            end
            S_DOWN: begin
              if (smp) begin
                // Hold counter saturates; long pulse fires on reaching LONG_N.
                if (fsm.hold != 8'(LONG_N)) begin
                  fsm.hold <= fsm.hold + 8'd1;
                  if (fsm.hold == 8'(LONG_N - 1)) begin
                    long_r <= 1'b1;
                  end
                end
              end else begin
                fsm.st  <= S_RCHK;
                fsm.cnt <= 4'd1;
              end
            end
            S_RCHK: begin
              if (!smp) begin
                if (fsm.cnt == 4'(DEB_N - 1)) begin
                  fsm.st  <= S_IDLE;
                  fsm.cnt <= '0;
                  lvl_r   <= 1'b0;
                end else begin
                  fsm.cnt <= fsm.cnt + 4'd1;
                end
              end else begin
                // Bounce during release: back to DOWN, hold count kept.
                fsm.st  <= S_DOWN;
                fsm.cnt <= '0;
              end
            end
            default: begin
              fsm.st  <= S_IDLE;
              fsm.cnt <= '0;
            end
          endcase
        end
      end
    end

    assign key_lvl[g]   = lvl_r;
    assign key_press[g] = press_r;
    assign key_long[g]  = long_r;
  end

  logic [7:0] pending;
  logic [7:0] load_mask;
  logic [2:0] sel;
  logic       load;

  // Lowest-index pending bit and whether it is moved into key_code this edge.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) begin
        sel = 3'(i);
      end
    end
    load      = (|pending) && (!code_valid || code_ack);
    load_mask = '0;
    if (load) begin
      load_mask[sel] = 1'b1;
    end
  end

  // Pending set / event presentation / sticky overflow.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      code_valid <= 1'b0;
      key_code   <= '0;
      ovf        <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | key_press;
      // A press on a bit being loaded this edge is a fresh event, not a loss.
      if (|(key_press & pending & ~load_mask)) begin
        ovf <= 1'b1;
      end
      if (load) begin
        code_valid <= 1'b1;
        key_code   <= sel;
      end else if (code_ack) begin
        code_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Directed bench for key_scan_debounce with TICK_DIV=4, DEB_N=3, LONG_N=5.
// Edge numbers count mclk rising edges after reset release; tick updates land
// on edges 4,8,12,...; a key driven before edge e is first sampled at the
// first tick edge >= e+2.
module tb_key_scan_debounce;

  logic       mclk;
  logic       rst;
  logic [7:0] key;
  logic [7:0] key_lvl;
  logic [7:0] key_press;
  logic [7:0] key_long;
  logic       code_valid;
  logic [2:0] key_code;
  logic       code_ack;
  logic       ovf;

  int checks;
  int errors;
  int edges;
  int long_cnt;
  logic [7:0] press_seen;
  logic [7:0] lvl_seen;
  logic       valid_seen;

  key_scan_debounce #(
    .TICK_DIV(4),
    .DEB_N   (3),
    .LONG_N  (5)
  ) dut (
    .mclk      (mclk),
    .rst       (rst),
    .key       (key),
    .key_lvl   (key_lvl),
    .key_press (key_press),
    .key_long  (key_long),
    .code_valid(code_valid),
    .key_code  (key_code),
    .code_ack  (code_ack),
    .ovf       (ovf)
  );

  // Clock and edge bookkeeping
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  always @(posedge mclk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(negedge mclk) begin
    if (!rst) begin
      press_seen = press_seen | key_press;
      lvl_seen   = lvl_seen | key_lvl;
      valid_seen = valid_seen | code_valid;
      if (key_long[5]) long_cnt = long_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic goto_edge(input int n);
    while (edges < n) @(negedge mclk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lvl"},   32'(key_lvl),    32'h0);
    chk({tag, "_press"}, 32'(key_press),  32'h0);
    chk({tag, "_long"},  32'(key_long),   32'h0);
    chk({tag, "_valid"}, 32'(code_valid), 32'h0);
    chk({tag, "_code"},  32'(key_code),   32'h0);
    chk({tag, "_ovf"},   32'(ovf),        32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    key      = 8'h00;
    code_ack = 1'b0;
    repeat (3) @(negedge mclk);
    chk_zero(tag);
    press_seen = '0;
    lvl_seen   = '0;
    valid_seen = 1'b0;
    long_cnt   = 0;
    rst        = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    key = 8'h00;
    code_ack = 1'b0;

    // Single key press: press accepted on the 3rd tick, event presented.
    do_reset("rst1");
    key = 8'h01;
    goto_edge(11);
    chk("k0_lvl_pre", 32'(key_lvl), 32'h00);
    goto_edge(12);
    chk("k0_lvl",   32'(key_lvl),   32'h01);
    chk("k0_press", 32'(key_press), 32'h01);
    goto_edge(13);
    chk("k0_press_end", 32'(key_press),  32'h00);
    chk("k0_valid_pre", 32'(code_valid), 32'h0);
    goto_edge(14);
    chk("k0_valid", 32'(code_valid), 32'h1);
    chk("k0_code",  32'(key_code),   32'h0);

    // Glitch of two samples: nothing reported.
    do_reset("rst2");
    key = 8'h04;
    goto_edge(6);
    key = 8'h00;
    goto_edge(24);
    chk("glitch_lvl",   32'(lvl_seen),   32'h00);
    chk("glitch_press", 32'(press_seen), 32'h00);
    chk("glitch_valid", 32'(valid_seen), 32'h0);

    // Long hold on key 5 and release.
    do_reset("rst3");
    key = 8'h20;
    goto_edge(12);
    chk("k5_press", 32'(key_press), 32'h20);
    goto_edge(14);
    chk("k5_code", 32'(key_code), 32'h5);
    goto_edge(31);
    chk("k5_long_pre", 32'(key_long), 32'h00);
    goto_edge(32);
    chk("k5_long", 32'(key_long), 32'h20);
    goto_edge(33);
    chk("k5_long_end", 32'(key_long), 32'h00);
    goto_edge(34);
    key = 8'h00;
    goto_edge(47);
    chk("k5_lvl_held", 32'(key_lvl), 32'h20);
    goto_edge(48);
    chk("k5_lvl_rel", 32'(key_lvl), 32'h00);
    chk("k5_long_cnt", 32'(long_cnt), 32'd1);

    // Simultaneous presses presented in ascending order.
    do_reset("rst4");
    key = 8'h42;
    goto_edge(12);
    chk("k16_press", 32'(key_press), 32'h42);
    goto_edge(14);
    chk("k16_valid", 32'(code_valid), 32'h1);
    chk("k16_code1", 32'(key_code),   32'h1);
    goto_edge(16);
    chk("k16_stable", 32'(key_code), 32'h1);
    code_ack = 1'b1;
    goto_edge(17);
    code_ack = 1'b0;
    chk("k16_code6",  32'(key_code),   32'h6);
    chk("k16_valid6", 32'(code_valid), 32'h1);
    goto_edge(19);
    chk("k16_hold6", 32'(key_code), 32'h6);
    code_ack = 1'b1;
    goto_edge(20);
    code_ack = 1'b0;
    chk("k16_empty", 32'(code_valid), 32'h0);

    // Repeated presses of key 3 without acknowledge: overflow.
    do_reset("rst5");
    key = 8'h08;
    goto_edge(12);
    key = 8'h00;
    goto_edge(14);
    chk("k3_code", 32'(key_code), 32'h3);
    goto_edge(24);
    key = 8'h08;
    goto_edge(36);
    chk("k3_press2", 32'(key_press), 32'h08);
    key = 8'h00;
    goto_edge(38);
    chk("k3_no_ovf", 32'(ovf), 32'h0);
    goto_edge(48);
    key = 8'h08;
    goto_edge(60);
    chk("k3_press3", 32'(key_press), 32'h08);
    goto_edge(61);
    chk("k3_ovf", 32'(ovf), 32'h1);
    code_ack = 1'b1;
    goto_edge(62);
    chk("k3_code2",  32'(key_code),   32'h3);
    chk("k3_valid2", 32'(code_valid), 32'h1);
    goto_edge(63);
    code_ack = 1'b0;
    chk("k3_one_evt",   32'(code_valid), 32'h0);
    chk("k3_ovf_stick", 32'(ovf),        32'h1);

    // Asynchronous reset with all keys down, then re-debounce.
    do_reset("rst6");
    key = 8'hFF;
    goto_edge(14);
    chk("all_lvl",   32'(key_lvl),    32'hFF);
    chk("all_valid", 32'(code_valid), 32'h1);
    #1 rst = 1'b1;
    #1 chk_zero("async");
    repeat (2) @(negedge mclk);
    rst = 1'b0;
    goto_edge(11);
    chk("rerun_lvl_pre",   32'(key_lvl),   32'h00);
    chk("rerun_press_pre", 32'(key_press), 32'h00);
    goto_edge(12);
    chk("rerun_lvl",   32'(key_lvl),   32'hFF);
    chk("rerun_press", 32'(key_press), 32'hFF);
    goto_edge(14);
    chk("rerun_code", 32'(key_code), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scan_debounce.md
KEY_SCAN_DEBOUNCE -- requirements
Module: key_scan_debounce

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, giving the number of mclk cycles per debounce sample tick (minimum 2).
REQ-002 The block SHALL have parameter DEB_N, default 4, giving the number of consecutive equal samples required to accept a key change (range 2..15).
REQ-003 The block SHALL have parameter LONG_N, default 64, giving the number of held ticks that qualify a press as a long press (range DEB_N+1..255).
REQ-004 mclk  input  1  the single system clock, rising-edge active.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key  input  8  raw asynchronous push-button levels, 1 = pressed.
REQ-007 key_lvl  output  8  debounced key levels, 1 = pressed.
REQ-008 key_press  output  8  one-mclk pulse per key on accepted press.
REQ-009 key_long  output  8  one-mclk pulse per key when hold reaches LONG_N ticks.
REQ-010 code_valid  output  1  key_code holds an unconsumed press event.
REQ-011 key_code  output  3  index of the pressed key, valid while code_valid=1.
REQ-012 code_ack  input  1  consumer acknowledge; an event is consumed on a cycle with code_valid=1 and code_ack=1.
REQ-013 ovf  output  1  sticky flag set when a press event is lost.

Function
REQ-014 Each key bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert an internal tick for exactly one mclk cycle when the count equals TICK_DIV-1.
REQ-016 Each key SHALL have an independent FSM with states IDLE, PCHK, DOWN and RCHK, a 4-bit sample counter and an 8-bit hold counter, all advancing only on tick cycles.
REQ-017 IDLE: a sample of 1 SHALL move the FSM to PCHK with cnt=1; a sample of 0 SHALL hold IDLE.
REQ-018 PCHK: a sample of 1 SHALL increment cnt, and reaching DEB_N SHALL move the FSM to DOWN, set key_lvl=1, pulse key_press and clear the hold counter; a sample of 0 SHALL return the FSM to IDLE with cnt=0.
REQ-019 DOWN: the hold counter SHALL increment per tick and saturate at LONG_N; key_long SHALL pulse once on the tick where the hold counter becomes LONG_N; a sample of 0 SHALL move the FSM to RCHK with cnt=1.
REQ-020 RCHK: a sample of 0 SHALL increment cnt, and reaching DEB_N SHALL move the FSM to IDLE with key_lvl=0; a sample of 1 SHALL return the FSM to DOWN with cnt=0 and the hold counter preserved.
REQ-021 The key_lvl, key_press and key_long outputs SHALL be registered and SHALL change on the mclk edge that ends the tick cycle, giving a latency of 1 mclk after the tick.
REQ-022 An 8-bit pending register SHALL set bit i on key_press[i].
REQ-023 Whenever code_valid=0, or code_valid=1 with code_ack=1, the lowest-index set pending bit SHALL load key_code, set code_valid and clear that pending bit on the same edge.
REQ-024 With no pending bit set, an acknowledge SHALL clear code_valid.
REQ-025 key_code and code_valid SHALL be stable while code_valid=1 and code_ack=0.
REQ-026 If key_press[i] occurs while pending bit i is already set, the block SHALL set ovf, keep bit i set and record one event only.
REQ-027 A press pulse and a load of the same bit on the same edge SHALL leave the bit set and SHALL NOT set ovf.
REQ-028 Simultaneous presses on several keys SHALL all be recorded in pending and presented in ascending index order.

Reset
REQ-029 While rst=1, all synchronizers, counters, FSMs (to IDLE), the pending register, key_lvl, key_press, key_long, key_code, code_valid and ovf SHALL be forced to 0 asynchronously.
REQ-030 Deassertion of rst during a key press SHALL restart debounce from IDLE, and no press SHALL be reported before DEB_N fresh 1-samples.
REQ-031 ovf SHALL be cleared only by rst.

Verification (TICK_DIV=4, DEB_N=3, LONG_N=5)
REQ-032 key[0] held at 1 -> key_lvl[0]=1 and one key_press[0] pulse on the 3rd tick, then code_valid=1 with key_code=0.
REQ-033 key[2] glitch high for 2 ticks then low -> no key_lvl, key_press or code_valid activity.
REQ-034 key[5] held 10 ticks -> key_long[5] pulses once, 5 ticks after entry to DOWN; release -> key_lvl[5]=0 after 3 zero samples.
REQ-035 key[1] and key[6] pressed together with code_ack=0 -> key_code=1; ack -> key_code=6 on the next cycle; ack -> code_valid=0.
REQ-036 key[3] pressed, released and pressed again without ack -> ovf=1 and one pending event for key 3.
REQ-037 rst pulsed while key_lvl=8'hFF and code_valid=1 -> all outputs read 0 immediately; held keys re-reported after 3 ticks.
